// File: rtl/nrisc_int_ctrl.sv
// Interrupt controller feeding the NRISC core INTERRUPT_flag/INTERRUPT_ch inputs.
// Optional macro INT_LEVEL_TRIG_EN selects level-sensitive lines instead of latched edges.

module nrisc_int_lane (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic ev
);
    logic s1, s2, p;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            p  <= s2;
        end
    end

`ifdef INT_LEVEL_TRIG_EN
    assign ev = s2;
    logic unused_p;
    assign unused_p = p;
`else
    assign ev = s2 & ~p;
`endif
endmodule

module nrisc_int_ctrl #(
    parameter int          N_IRQ    = 8,
    parameter logic [7:0]  CH_BASE  = 8'h00,
    parameter logic [7:0]  MASK_RST = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] IRQ_in,
    input  logic             INT_ack,
    input  logic             INT_ret,
    input  logic [N_IRQ-1:0] INT_MASK_in,
    input  logic             INT_MASK_write,
    input  logic [N_IRQ-1:0] INT_CLR_in,
    input  logic             INT_CLR_write,
    output logic [N_IRQ-1:0] INT_MASK_out,
    output logic [N_IRQ-1:0] INT_PEND_out,
    output logic             INTERRUPT_flag,
    output logic [7:0]       INTERRUPT_ch
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    logic [1:0]       state;
    logic [2:0]       idx, sel_idx;
    logic             sel_vld;
    logic [N_IRQ-1:0] ev, pend, mask, mask_eff, pend_eff, cand, pend_nxt, ack_clr;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_lane
        nrisc_int_lane u_lane (.clk(clk), .rst(rst), .irq(IRQ_in[i]), .ev(ev[i]));
    end

    // Register writes landing this edge are already honoured by this edge's decision.
    assign mask_eff = INT_MASK_write ? INT_MASK_in : mask;
`ifdef INT_LEVEL_TRIG_EN
    assign pend_eff = pend;
    logic unused_clr;
    assign unused_clr = INT_CLR_write ^ (|INT_CLR_in);
`else
    assign pend_eff = INT_CLR_write ? (pend & ~INT_CLR_in) : pend;
`endif
    assign cand    = pend_eff & mask_eff;
    assign ack_clr = (state == ST_REQ && INT_ack) ? (N_IRQ'(1) << idx) : '0;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_vld = 1'b1;
                sel_idx = 3'(i);
            end
        end
    end

    // New events are ORed in last so a same-cycle clear never drops them.
    always_comb begin
`ifdef INT_LEVEL_TRIG_EN
        pend_nxt = ev;
`else
        pend_nxt = (pend_eff & ~ack_clr) | ev;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= 3'd0;
            INTERRUPT_ch <= CH_BASE;
            pend         <= '0;
            mask         <= MASK_RST[N_IRQ-1:0];
        end else begin
            pend <= pend_nxt;
            if (INT_MASK_write)
                mask <= INT_MASK_in;
            case (state)
                ST_IDLE: if (sel_vld) begin
                    idx          <= sel_idx;
                    INTERRUPT_ch <= CH_BASE + {5'd0, sel_idx};
                    state        <= ST_REQ;
                end
                ST_REQ:  if (INT_ack) state <= ST_SVC;
                ST_SVC:  if (INT_ret) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign INTERRUPT_flag = (state != ST_IDLE);
    assign INT_MASK_out   = mask;
    assign INT_PEND_out   = pend;
endmodule

// File: tb/tb_nrisc_int_ctrl.sv
// Directed bench for nrisc_int_ctrl in its default edge-triggered build.

module tb_nrisc_int_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] IRQ_in, INT_MASK_in, INT_CLR_in;
    logic       INT_ack, INT_ret, INT_MASK_write, INT_CLR_write;
    logic [7:0] INT_MASK_out, INT_PEND_out, INTERRUPT_ch;
    logic       INTERRUPT_flag;
    int         passed = 0;
    int         total  = 0;

    nrisc_int_ctrl #(.N_IRQ(8), .CH_BASE(8'h00), .MASK_RST(8'hFF)) dut (
        .clk(clk), .rst(rst), .IRQ_in(IRQ_in), .INT_ack(INT_ack), .INT_ret(INT_ret),
        .INT_MASK_in(INT_MASK_in), .INT_MASK_write(INT_MASK_write),
        .INT_CLR_in(INT_CLR_in), .INT_CLR_write(INT_CLR_write),
        .INT_MASK_out(INT_MASK_out), .INT_PEND_out(INT_PEND_out),
        .INTERRUPT_flag(INTERRUPT_flag), .INTERRUPT_ch(INTERRUPT_ch)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic ack();
        INT_ack = 1'b1; step(); INT_ack = 1'b0;
    endtask

    task automatic ret();
        INT_ret = 1'b1; step(); INT_ret = 1'b0;
    endtask

    task automatic wmask(input logic [7:0] m);
        INT_MASK_in = m; INT_MASK_write = 1'b1; step(); INT_MASK_write = 1'b0;
    endtask

    initial begin
        rst = 1'b1; IRQ_in = 8'h00; INT_ack = 1'b0; INT_ret = 1'b0;
        INT_MASK_in = 8'h00; INT_MASK_write = 1'b0; INT_CLR_in = 8'h00; INT_CLR_write = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_flag", {7'd0, INTERRUPT_flag}, 8'h00);
        chk("rst_ch",   INTERRUPT_ch, 8'h00);
        chk("rst_pend", INT_PEND_out, 8'h00);
        chk("rst_mask", INT_MASK_out, 8'hFF);

        // 1: single line 2, three-edge pending latency, flag one edge later
        IRQ_in = 8'h04;
        step(2);
        chk("t1_pend_early", INT_PEND_out, 8'h00);
        step();
        chk("t1_pend", INT_PEND_out, 8'h04);
        chk("t1_flag_early", {7'd0, INTERRUPT_flag}, 8'h00);
        step();
        chk("t1_flag", {7'd0, INTERRUPT_flag}, 8'h01);
        chk("t1_ch", INTERRUPT_ch, 8'h02);
        step();
        ack();
        chk("t1_pend_ack", INT_PEND_out, 8'h00);
        chk("t1_flag_svc", {7'd0, INTERRUPT_flag}, 8'h01);
        step(3);
        ret();
        chk("t1_flag_ret", {7'd0, INTERRUPT_flag}, 8'h00);

        // 2: lines 5 and 1 together, priority then back-to-back service
        IRQ_in = 8'h00; step(3);
        IRQ_in = 8'h22; step(3);
        chk("t2_pend", INT_PEND_out, 8'h22);
        step();
        chk("t2_ch1", INTERRUPT_ch, 8'h01);
        ack();
        chk("t2_pend_ack", INT_PEND_out, 8'h20);
        ret();
        chk("t2_idle", {7'd0, INTERRUPT_flag}, 8'h00);
        step();
        chk("t2_flag5", {7'd0, INTERRUPT_flag}, 8'h01);
        chk("t2_ch5", INTERRUPT_ch, 8'h05);
        ack(); ret();
        chk("t2_pend_done", INT_PEND_out, 8'h00);

        // 3: masked line stays pending, unmask releases it
        IRQ_in = 8'h00; step(3);
        wmask(8'hFE);
        chk("t3_mask", INT_MASK_out, 8'hFE);
        IRQ_in = 8'h01; step(4);
        chk("t3_pend", INT_PEND_out, 8'h01);
        chk("t3_flag_masked", {7'd0, INTERRUPT_flag}, 8'h00);
        wmask(8'hFF);
        step();
        chk("t3_flag", {7'd0, INTERRUPT_flag}, 8'h01);
        chk("t3_ch", INTERRUPT_ch, 8'h00);
        ack(); ret();

        // 4: new rise of line 3 in the ack cycle survives the ack-clear
        IRQ_in = 8'h00; step(3);
        IRQ_in = 8'h08; step(4);
        chk("t4_ch", INTERRUPT_ch, 8'h03);
        IRQ_in = 8'h00; step(3);
        IRQ_in = 8'h08; step(2);
        ack();
        chk("t4_pend_kept", INT_PEND_out, 8'h08);
        ret();
        step();
        chk("t4_reflag", {7'd0, INTERRUPT_flag}, 8'h01);
        chk("t4_rech", INTERRUPT_ch, 8'h03);
        ack();
        chk("t4_pend_clr", INT_PEND_out, 8'h00);
        ret();

        // 5: software clear, stray ack/ret, ack+ret together
        IRQ_in = 8'h00; step(3);
        wmask(8'h00);
        IRQ_in = 8'h06; step(3);
        chk("t5_pend", INT_PEND_out, 8'h06);
        INT_CLR_in = 8'h02; INT_CLR_write = 1'b1; step(); INT_CLR_write = 1'b0;
        chk("t5_clr", INT_PEND_out, 8'h04);
        ack();
        chk("t5_ack_idle", {7'd0, INTERRUPT_flag}, 8'h00);
        wmask(8'hFF);
        chk("t5_req", {7'd0, INTERRUPT_flag}, 8'h01);
        chk("t5_ch", INTERRUPT_ch, 8'h02);
        ret();
        chk("t5_ret_req", {7'd0, INTERRUPT_flag}, 8'h01);
        chk("t5_pend_req", INT_PEND_out, 8'h04);
        INT_ack = 1'b1; INT_ret = 1'b1; step(); INT_ack = 1'b0; INT_ret = 1'b0;
        chk("t5_both_flag", {7'd0, INTERRUPT_flag}, 8'h01);
        chk("t5_both_pend", INT_PEND_out, 8'h00);
        ret();
        chk("t5_done", {7'd0, INTERRUPT_flag}, 8'h00);

        // 6: reset mid-service discards pending and restores mask
        IRQ_in = 8'h00; step(3);
        IRQ_in = 8'h80; step(4);
        chk("t6_ch", INTERRUPT_ch, 8'h07);
        ack();
        IRQ_in = 8'h00; step(3);
        IRQ_in = 8'h80; step(3);
        chk("t6_pend", INT_PEND_out, 8'h80);
        wmask(8'h0F);
        chk("t6_mask", INT_MASK_out, 8'h0F);
        rst = 1'b1; IRQ_in = 8'h00; step(); rst = 1'b0;
        chk("t6_flag", {7'd0, INTERRUPT_flag}, 8'h00);
        chk("t6_pend_rst", INT_PEND_out, 8'h00);
        chk("t6_mask_rst", INT_MASK_out, 8'hFF);
        chk("t6_ch_rst", INTERRUPT_ch, 8'h00);
        step(4);
        chk("t6_quiet", {7'd0, INTERRUPT_flag}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
